// File: rtl/money_ledger_pkg.sv
// Shared constants for the vending ledger: FSM encoding, price table,
// coin denominations and the greedy change helper.
package money_pkg;

    localparam int CREDIT_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        PAY      = 3'd2,
        CHANGE   = 3'd3,
        DISPENSE = 3'd4
    } ledger_state_t;

    localparam logic [5:0] DENOM_50 = 6'd50;
    localparam logic [5:0] DENOM_20 = 6'd20;
    localparam logic [5:0] DENOM_10 = 6'd10;
    localparam logic [5:0] DENOM_5  = 6'd5;
    localparam logic [5:0] DENOM_1  = 6'd1;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [2:0] code);
        logic [CREDIT_W-1:0] price;
        case (code)
            3'd1:    price = 8'd2;
            3'd2:    price = 8'd3;
            3'd3:    price = 8'd5;
            3'd4:    price = 8'd7;
            3'd5:    price = 8'd10;
            3'd6:    price = 8'd12;
            3'd7:    price = 8'd15;
            default: price = 8'd0;
        endcase
        return price;
    endfunction

    // Largest denomination not exceeding the amount; 0 only for a zero amount.
    function automatic logic [5:0] greedy_pick(input logic [CREDIT_W-1:0] amount);
        logic [5:0] coin;
        if (amount >= 8'(DENOM_50))      coin = DENOM_50;
        else if (amount >= 8'(DENOM_20)) coin = DENOM_20;
        else if (amount >= 8'(DENOM_10)) coin = DENOM_10;
        else if (amount >= 8'(DENOM_5))  coin = DENOM_5;
        else if (amount >= 8'(DENOM_1))  coin = DENOM_1;
        else                             coin = 6'd0;
        return coin;
    endfunction

endpackage

// File: rtl/money_ledger_if.sv
// Key-pulse, switch and display-value bundle between the panel logic and the ledger.
interface money_ledger_if;
    logic       in_money_one;
    logic       in_money_five;
    logic       in_money_ten;
    logic       in_money_twenty;
    logic       in_money_fifty;
    logic       sys_Goods;
    logic       sys_Confirm;
    logic       sys_Cancel;
    logic       sys_Change;
    logic [2:0] type_SW_high;
    logic [2:0] type_SW_low;
    logic [1:0] num_SW;
    logic [7:0] need_money;
    logic [7:0] input_money;
    logic [7:0] change_money;
    logic [5:0] change_coin;
    logic       change_coin_valid;
    logic       coin_reject;
    logic       vend_done;
    logic [2:0] ledger_state;

    modport master (
        output in_money_one, in_money_five, in_money_ten, in_money_twenty, in_money_fifty,
        output sys_Goods, sys_Confirm, sys_Cancel, sys_Change,
        output type_SW_high, type_SW_low, num_SW,
        input  need_money, input_money, change_money, change_coin, change_coin_valid,
        input  coin_reject, vend_done, ledger_state
    );

    modport slave (
        input  in_money_one, in_money_five, in_money_ten, in_money_twenty, in_money_fifty,
        input  sys_Goods, sys_Confirm, sys_Cancel, sys_Change,
        input  type_SW_high, type_SW_low, num_SW,
        output need_money, input_money, change_money, change_coin, change_coin_valid,
        output coin_reject, vend_done, ledger_state
    );
endinterface

// File: rtl/money_ledger_change_dispenser.sv
// Paces change out as greedy denomination strobes separated by GAP idle cycles.
// The owner keeps the running amount and subtracts pick whenever fire is high.
module change_dispenser
    import money_pkg::*;
#(
    parameter int unsigned GAP = 4
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] amount,
    output logic                fire,
    output logic [5:0]          pick,
    output logic                busy,
    output logic [5:0]          coin,
    output logic                coin_valid,
    output logic                done
);
    localparam int GAP_W = $clog2(GAP + 1);

    logic [GAP_W-1:0] gap_reg;
    logic             busy_reg;
    logic [5:0]       coin_reg;
    logic             coin_valid_reg;
    logic             done_reg;
    logic             last_coin;

    assign pick      = greedy_pick(amount);
    assign fire      = busy_reg && (gap_reg == '0) && (amount != '0);
    assign last_coin = (amount == {2'b00, pick});

    always_ff @(posedge clk) begin
        if (srst) begin
            gap_reg        <= '0;
            busy_reg       <= 1'b0;
            coin_reg       <= '0;
            coin_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            coin_valid_reg <= fire;
            done_reg       <= fire && last_coin;
            if (fire) begin
                coin_reg <= pick;
            end
            if (load) begin
                busy_reg <= 1'b1;
                gap_reg  <= '0;
            end else if (fire) begin
                gap_reg <= GAP_W'(GAP);
                if (last_coin) begin
                    busy_reg <= 1'b0;
                end
            end else if (busy_reg && gap_reg != '0) begin
                gap_reg <= gap_reg - GAP_W'(1);
            end
        end
    end

    assign busy       = busy_reg;
    assign coin       = coin_reg;
    assign coin_valid = coin_valid_reg;
    assign done       = done_reg;
endmodule

// File: rtl/money_ledger.sv
// Vending transaction controller: latches orders, accumulates credit,
// settles purchases or refunds and hands the change to the dispenser.
module money_ledger
    import money_pkg::*;
#(
    parameter int unsigned DISPENSE_GAP = 4,
    parameter int unsigned MAX_CREDIT   = 199
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    money_ledger_if.slave bus
);
    ledger_state_t       state_reg;
    logic [CREDIT_W-1:0] need_reg;
    logic [CREDIT_W-1:0] credit_reg;
    logic [CREDIT_W-1:0] change_reg;
    logic                coin_reject_reg;
    logic                vend_done_reg;

    logic [CREDIT_W-1:0] pair_price;
    logic [CREDIT_W-1:0] order_value;
    logic [6:0]          coin_sum;
    logic [CREDIT_W:0]   credit_total;
    logic                coin_any;
    logic                button_any;
    logic                coin_taken;
    logic                credit_fits;

    logic                disp_load;
    logic                disp_fire;
    logic [5:0]          disp_pick;
    logic                disp_busy;
    logic                disp_done;

    assign pair_price  = price_of(bus.type_SW_high) + price_of(bus.type_SW_low);
    assign order_value = pair_price * {6'd0, bus.num_SW};

    assign coin_sum = (bus.in_money_one    ? 7'd1  : 7'd0)
                    + (bus.in_money_five   ? 7'd5  : 7'd0)
                    + (bus.in_money_ten    ? 7'd10 : 7'd0)
                    + (bus.in_money_twenty ? 7'd20 : 7'd0)
                    + (bus.in_money_fifty  ? 7'd50 : 7'd0);
    assign coin_any     = bus.in_money_one | bus.in_money_five | bus.in_money_ten
                        | bus.in_money_twenty | bus.in_money_fifty;
    assign button_any   = bus.sys_Cancel | bus.sys_Confirm | bus.sys_Goods;
    // Any higher-priority button in the same cycle swallows the coins entirely.
    assign coin_taken   = coin_any && !button_any;
    assign credit_total = {1'b0, credit_reg} + {2'b00, coin_sum};
    assign credit_fits  = credit_total <= (CREDIT_W + 1)'(MAX_CREDIT);

    assign disp_load = (state_reg == CHANGE) && bus.sys_Change
                    && (change_reg != '0) && !disp_busy;

    change_dispenser #(.GAP(DISPENSE_GAP)) u_dispenser (
        .clk        (sys_clk),
        .srst       (sys_rst),
        .load       (disp_load),
        .amount     (change_reg),
        .fire       (disp_fire),
        .pick       (disp_pick),
        .busy       (disp_busy),
        .coin       (bus.change_coin),
        .coin_valid (bus.change_coin_valid),
        .done       (disp_done)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg       <= IDLE;
            need_reg        <= '0;
            credit_reg      <= '0;
            change_reg      <= '0;
            coin_reject_reg <= 1'b0;
            vend_done_reg   <= 1'b0;
        end else begin
            coin_reject_reg <= 1'b0;
            vend_done_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.sys_Goods && !bus.sys_Cancel && !bus.sys_Confirm) begin
                        if (order_value != '0) begin
                            need_reg  <= order_value;
                            state_reg <= SELECT;
                        end
                    end else if (coin_taken) begin
                        coin_reject_reg <= 1'b1;
                    end
                end
                SELECT: begin
                    if (bus.sys_Cancel) begin
                        need_reg  <= '0;
                        state_reg <= IDLE;
                    end else if (bus.sys_Confirm) begin
                        state_reg <= PAY;
                    end else if (bus.sys_Goods) begin
                        if (order_value != '0) begin
                            need_reg <= order_value;
                        end
                    end else if (coin_taken) begin
                        coin_reject_reg <= 1'b1;
                    end
                end
                PAY: begin
                    if (bus.sys_Cancel) begin
                        change_reg <= credit_reg;
                        need_reg   <= '0;
                        credit_reg <= '0;
                        state_reg  <= CHANGE;
                    end else if (bus.sys_Confirm) begin
                        if (credit_reg >= need_reg) begin
                            change_reg    <= credit_reg - need_reg;
                            need_reg      <= '0;
                            credit_reg    <= '0;
                            vend_done_reg <= 1'b1;
                            state_reg     <= CHANGE;
                        end
                    end else if (coin_taken) begin
                        if (credit_fits) begin
                            credit_reg <= credit_total[CREDIT_W-1:0];
                        end else begin
                            coin_reject_reg <= 1'b1;
                        end
                    end
                end
                CHANGE: begin
                    if (bus.sys_Change) begin
                        state_reg <= (change_reg == '0) ? IDLE : DISPENSE;
                    end
                    if (coin_taken) begin
                        coin_reject_reg <= 1'b1;
                    end
                end
                DISPENSE: begin
                    if (disp_fire) begin
                        change_reg <= change_reg - {2'b00, disp_pick};
                    end
                    if (disp_done) begin
                        state_reg <= IDLE;
                    end
                    if (coin_taken) begin
                        coin_reject_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.need_money   = need_reg;
    assign bus.input_money  = credit_reg;
    assign bus.change_money = change_reg;
    assign bus.coin_reject  = coin_reject_reg;
    assign bus.vend_done    = vend_done_reg;
    assign bus.ledger_state = state_reg;
endmodule

// File: tb/tb_money_ledger.sv
// Directed bench for money_ledger: walks purchase, overflow, refund and
// mid-dispense reset scenarios against hand-computed values.
module tb_money_ledger;
    localparam int GAP = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   strobe_n;
    int   strobe_coin[16];
    int   strobe_cyc[16];
    int   cyc;

    money_ledger_if bus();

    money_ledger #(.DISPENSE_GAP(GAP), .MAX_CREDIT(199)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clear_pulses();
        bus.in_money_one    = 1'b0;
        bus.in_money_five   = 1'b0;
        bus.in_money_ten    = 1'b0;
        bus.in_money_twenty = 1'b0;
        bus.in_money_fifty  = 1'b0;
        bus.sys_Goods       = 1'b0;
        bus.sys_Confirm     = 1'b0;
        bus.sys_Cancel      = 1'b0;
        bus.sys_Change      = 1'b0;
    endtask

    // One clock: inputs set beforehand are sampled; outputs settle by #1.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        clear_pulses();
    endtask

    task automatic run_dispense();
        bit finished;
        finished = 1'b0;
        strobe_n = 0;
        for (int c = 0; c < 200 && !finished; c++) begin
            cycle();
            if (bus.change_coin_valid) begin
                if (strobe_n < 16) begin
                    strobe_coin[strobe_n] = int'(bus.change_coin);
                    strobe_cyc[strobe_n]  = cyc;
                end
                strobe_n++;
                $display("strobe coin=%0d change_left=%0d", bus.change_coin, bus.change_money);
            end
            if (bus.ledger_state == 3'd0) finished = 1'b1;
        end
        check_val("dispense_ends_idle", int'(finished), 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        clear_pulses();
        bus.type_SW_high = 3'd0;
        bus.type_SW_low  = 3'd0;
        bus.num_SW       = 2'd0;
        cycle();
        cycle();
        check_val("rst_need", int'(bus.need_money), 0);
        check_val("rst_input", int'(bus.input_money), 0);
        check_val("rst_change", int'(bus.change_money), 0);
        check_val("rst_state", int'(bus.ledger_state), 0);
        check_val("rst_valid", int'(bus.change_coin_valid), 0);
        rst = 1'b0;
        cycle();

        // Order 14: (5 + 2) x 2, exact-ish purchase leaving 1 change.
        bus.type_SW_high = 3'd3;
        bus.type_SW_low  = 3'd1;
        bus.num_SW       = 2'd2;
        bus.sys_Goods = 1'b1; cycle();
        $display("goods need=%0d state=%0d", bus.need_money, bus.ledger_state);
        check_val("t1_need", int'(bus.need_money), 14);
        check_val("t1_state_sel", int'(bus.ledger_state), 1);
        bus.sys_Confirm = 1'b1; cycle();
        check_val("t1_state_pay", int'(bus.ledger_state), 2);
        bus.in_money_ten = 1'b1; cycle();
        check_val("t1_input10", int'(bus.input_money), 10);
        bus.in_money_five = 1'b1; cycle();
        check_val("t1_input15", int'(bus.input_money), 15);
        bus.sys_Confirm = 1'b1; cycle();
        $display("confirm vend=%0d change=%0d", bus.vend_done, bus.change_money);
        check_val("t1_vend", int'(bus.vend_done), 1);
        check_val("t1_change", int'(bus.change_money), 1);
        check_val("t1_need0", int'(bus.need_money), 0);
        check_val("t1_input0", int'(bus.input_money), 0);
        check_val("t1_state_chg", int'(bus.ledger_state), 3);
        bus.sys_Change = 1'b1; cycle();
        check_val("t1_vend_low", int'(bus.vend_done), 0);
        check_val("t1_state_disp", int'(bus.ledger_state), 4);
        run_dispense();
        check_val("t1_strobes", strobe_n, 1);
        check_val("t1_coin", strobe_coin[0], 1);
        check_val("t1_change_end", int'(bus.change_money), 0);

        // Credit ceiling: fourth 50 would reach 200 and is refused.
        bus.sys_Goods = 1'b1; cycle();
        bus.sys_Confirm = 1'b1; cycle();
        for (int i = 0; i < 3; i++) begin
            bus.in_money_fifty = 1'b1; cycle();
        end
        check_val("t2_input150", int'(bus.input_money), 150);
        bus.in_money_fifty = 1'b1; cycle();
        $display("overflow coin reject=%0d input=%0d", bus.coin_reject, bus.input_money);
        check_val("t2_reject", int'(bus.coin_reject), 1);
        check_val("t2_input_kept", int'(bus.input_money), 150);
        bus.sys_Cancel = 1'b1; cycle();
        check_val("t2_refund", int'(bus.change_money), 150);
        check_val("t2_state_chg", int'(bus.ledger_state), 3);
        bus.sys_Change = 1'b1; cycle();
        run_dispense();
        check_val("t2_strobes", strobe_n, 3);
        check_val("t2_coin0", strobe_coin[0], 50);
        check_val("t2_coin1", strobe_coin[1], 50);
        check_val("t2_coin2", strobe_coin[2], 50);
        check_val("t2_gap01", strobe_cyc[1] - strobe_cyc[0], GAP + 1);
        check_val("t2_gap12", strobe_cyc[2] - strobe_cyc[1], GAP + 1);

        // Same-cycle coins sum; Cancel beats Confirm.
        bus.sys_Goods = 1'b1; cycle();
        bus.sys_Confirm = 1'b1; cycle();
        bus.in_money_one = 1'b1; bus.in_money_five = 1'b1; bus.in_money_twenty = 1'b1; cycle();
        $display("multi coin input=%0d", bus.input_money);
        check_val("t3_input26", int'(bus.input_money), 26);
        bus.sys_Cancel = 1'b1; bus.sys_Confirm = 1'b1; cycle();
        check_val("t3_no_vend", int'(bus.vend_done), 0);
        check_val("t3_refund", int'(bus.change_money), 26);
        check_val("t3_state_chg", int'(bus.ledger_state), 3);
        bus.sys_Change = 1'b1; cycle();
        run_dispense();
        check_val("t3_strobes", strobe_n, 3);
        check_val("t3_coin0", strobe_coin[0], 20);
        check_val("t3_coin1", strobe_coin[1], 5);
        check_val("t3_coin2", strobe_coin[2], 1);

        // Coin in IDLE is refused; zero-quantity order is ignored.
        bus.in_money_one = 1'b1; cycle();
        check_val("t4_idle_reject", int'(bus.coin_reject), 1);
        check_val("t4_idle_input", int'(bus.input_money), 0);
        bus.num_SW = 2'd0;
        bus.sys_Goods = 1'b1; cycle();
        check_val("t4_zero_state", int'(bus.ledger_state), 0);
        check_val("t4_zero_need", int'(bus.need_money), 0);

        // Refund 86, then reset after the second strobe.
        bus.num_SW = 2'd2;
        bus.sys_Goods = 1'b1; cycle();
        bus.sys_Confirm = 1'b1; cycle();
        bus.in_money_fifty = 1'b1; cycle();
        bus.in_money_twenty = 1'b1; cycle();
        bus.in_money_ten = 1'b1; cycle();
        bus.in_money_five = 1'b1; cycle();
        bus.in_money_one = 1'b1; cycle();
        check_val("t5_input86", int'(bus.input_money), 86);
        bus.sys_Cancel = 1'b1; cycle();
        check_val("t5_refund", int'(bus.change_money), 86);
        bus.sys_Change = 1'b1; cycle();
        strobe_n = 0;
        for (int c = 0; c < 100 && strobe_n < 2; c++) begin
            cycle();
            if (bus.change_coin_valid) begin
                strobe_coin[strobe_n] = int'(bus.change_coin);
                strobe_n++;
                $display("strobe coin=%0d change_left=%0d", bus.change_coin, bus.change_money);
            end
        end
        check_val("t5_two_strobes", strobe_n, 2);
        check_val("t5_coin0", strobe_coin[0], 50);
        check_val("t5_coin1", strobe_coin[1], 20);
        check_val("t5_left16", int'(bus.change_money), 16);
        rst = 1'b1; cycle();
        rst = 1'b0;
        check_val("t5_rst_state", int'(bus.ledger_state), 0);
        check_val("t5_rst_change", int'(bus.change_money), 0);
        check_val("t5_rst_valid", int'(bus.change_coin_valid), 0);
        check_val("t5_rst_coin", int'(bus.change_coin), 0);
        strobe_n = 0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (bus.change_coin_valid) strobe_n++;
        end
        $display("after reset strobes=%0d", strobe_n);
        check_val("t5_no_more", strobe_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
